// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block: state encoding,
// register index width and the default memory-wait timeout.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int MEM_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register x0 never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idRs1,
    input  logic [REG_IDX_W-1:0] idRs2,
    input  logic                 idUseRs1,
    input  logic                 idUseRs2,
    input  logic                 exMemRead,
    input  logic [REG_IDX_W-1:0] exRd,
    output logic                 loadUse
);

    // Pure combinational match of EX destination against ID sources
    always_comb begin
        loadUse = exMemRead && (exRd != '0) &&
                  ((idUseRs1 && (idRs1 == exRd)) ||
                   (idUseRs2 && (idRs2 == exRd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stage enables and bubble insertion for load-use
// hazards, taken branches and memory waits, with a memory timeout that
// latches an error until reset, plus a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 err,
    output logic [15:0]          stall_cycles
);

    // Wait counter is at least 8 bits and always wide enough for the limit
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            state, nextState;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic [15:0]       stallCnt;
    logic              loadUse;
    logic              runSteer;

    hazard_detect uHazard (
        .idRs1     (id_rs1),
        .idRs2     (id_rs2),
        .idUseRs1  (id_use_rs1),
        .idUseRs2  (id_use_rs2),
        .exMemRead (ex_memread),
        .exRd      (ex_rd),
        .loadUse   (loadUse)
    );

    // State, wait counter and saturating stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            waitCnt  <= '0;
            stallCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitNext;
            if (!pc_en && (stallCnt != '1))
                stallCnt <= stallCnt + 16'd1;
        end
    end

    // Next-state and enable/flush decode; RUN and the ready cycle of
    // MEM_WAIT share the same branch/load-use steering via runSteer
    always_comb begin
        nextState  = state;
        waitNext   = waitCnt;
        runSteer   = 1'b0;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    nextState = MEM_WAIT;
                    waitNext  = WAIT_W'(1);
                end else begin
                    runSteer = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    nextState = RUN;
                    runSteer  = 1'b1;
                end else if (waitCnt >= WAIT_LIMIT) begin
                    nextState = ERROR;
                end else begin
                    waitNext = waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                nextState = ERROR;
            end
        endcase

        if (runSteer) begin
            if (ex_branch_taken) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loadUse) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
            end
        end

        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    assign err          = (state == ERROR);
    assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: a table of single-cycle RUN-state
// vectors followed by hand-written memory wait, timeout and saturation
// sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, err;
    logic [15:0] stall_cycles;

    int tests    = 0;
    int failures = 0;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] C_ZERO = 7'b00000_00;
    localparam logic [6:0] C_RUN  = 7'b11111_00;
    localparam logic [6:0] C_BR   = 7'b11111_11;
    localparam logic [6:0] C_LU   = 7'b00111_01;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       memRead;
        logic [4:0] rd;
        logic       branch;
        logic       memReq;
        logic       memReady;
        logic [6:0] expCtrl;
    } vec_t;

    vec_t vecs[10];

    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .err             (err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_memread = 0; ex_rd = '0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // One rising edge, then return on the falling edge for stable sampling
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0, C_RUN}; // no match
        vecs[1] = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, C_LU};  // load x5, rs1=5
        vecs[2] = '{5'd1, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, C_LU};  // rs2 match
        vecs[3] = '{5'd1, 5'd7, 1, 0, 1, 5'd7, 0, 0, 0, C_RUN}; // rs2 not used
        vecs[4] = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, C_RUN}; // x0 never hazards
        vecs[5] = '{5'd9, 5'd0, 1, 0, 0, 5'd9, 0, 0, 0, C_RUN}; // not a load
        vecs[6] = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, C_BR};  // branch beats load-use
        vecs[7] = '{5'd1, 5'd2, 0, 0, 0, 5'd3, 1, 0, 0, C_BR};  // branch alone
        vecs[8] = '{5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 1, 1, C_LU};  // ready access, hazard
        vecs[9] = '{5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 1, 1, C_RUN}; // ready access, no stall

        setIdle();
        rst = 1'b1;
        @(negedge clk);

        // Reset: outputs forced low while rst is high, registers cleared
        #1 check("rst_ctrl", 32'(ctrl()), 32'(C_ZERO));
        step();
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1 check("first_run", 32'(ctrl()), 32'(C_RUN));
        step();

        // Table-driven RUN-state vectors
        for (int i = 0; i < 10; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
            ex_memread = vecs[i].memRead; ex_rd = vecs[i].rd;
            ex_branch_taken = vecs[i].branch;
            mem_req = vecs[i].memReq; mem_ready = vecs[i].memReady;
            #1 check($sformatf("vec%0d", i), 32'(ctrl()), 32'(vecs[i].expCtrl));
            step();
        end
        setIdle();
        check("vec_stall_count", 32'(stall_cycles), 32'd3);

        // Single load-use bubble then stall count of 1
        doReset();
        id_rs1 = 5'd5; id_use_rs1 = 1; ex_memread = 1; ex_rd = 5'd5;
        #1 check("lu_bubble", 32'(ctrl()), 32'(C_LU));
        step();
        setIdle();
        #1 check("lu_after", 32'(ctrl()), 32'(C_RUN));
        check("lu_stall", 32'(stall_cycles), 32'd1);

        // Memory wait: 3 not-ready cycles, then ready
        doReset();
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("mw_hold%0d", k), 32'(ctrl()), 32'(C_ZERO));
            step();
        end
        mem_ready = 1;
        #1 check("mw_ready", 32'(ctrl()), 32'(C_RUN));
        step();
        setIdle();
        check("mw_stall", 32'(stall_cycles), 32'd3);
        #1 check("mw_back_run", 32'(ctrl()), 32'(C_RUN));

        // Ready on the timeout cycle wins; branch steering applies on it
        doReset();
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 4; k++) step();
        mem_ready = 1; ex_branch_taken = 1;
        #1 check("to_edge_ready", 32'(ctrl()), 32'(C_BR));
        step();
        setIdle();
        check("to_edge_err", 32'(err), 32'd0);
        #1 check("to_edge_run", 32'(ctrl()), 32'(C_RUN));

        // Timeout: RUN entry plus 4 wait cycles, then sticky error
        doReset();
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("to_noerr%0d", k), 32'(err), 32'd0);
            step();
        end
        check("to_err", 32'(err), 32'd1);
        mem_req = 0; mem_ready = 1;
        step();
        step();
        check("to_err_sticky", 32'(err), 32'd1);
        #1 check("to_err_ctrl", 32'(ctrl()), 32'(C_ZERO));

        // Saturation: preload near the top while stalled in ERROR
        force dut.stallCnt = 16'hFFFE;
        #1 release dut.stallCnt;
        check("sat_preload", 32'(stall_cycles), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("sat%0d", k), 32'(stall_cycles), 32'hFFFF);
        end

        // Reset leaves ERROR
        rst = 1'b1;
        #1 check("err_rst_ctrl", 32'(ctrl()), 32'(C_ZERO));
        step();
        rst = 1'b0;
        setIdle();
        check("err_rst_err", 32'(err), 32'd0);
        check("err_rst_stall", 32'(stall_cycles), 32'd0);
        #1 check("err_rst_run", 32'(ctrl()), 32'(C_RUN));

        // Reset in the middle of MEM_WAIT returns to RUN
        mem_req = 1; mem_ready = 0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        setIdle();
        #1 check("mw_rst_run", 32'(ctrl()), 32'(C_RUN));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
